udp_rx_parser: RTL and testbench



---
 rtl/udp_rx_parser.sv | 259 +++++++++++++++++++++++++
 tb/tb_udp_rx_parser.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: receive-side Ethernet/IPv4/UDP header parser.
// Consumes one frame byte per beat (FCS already stripped). It checks the
// Ethernet, IPv4 and UDP headers, forwards the payload of accepted datagrams
// as a byte stream and presents registered metadata for it. Frames that fail
// a check are consumed without output and flagged by a one-cycle drop pulse.
//
// Ports
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_rx_valid/data/last/user input byte stream (user = frame error on last)
//   o_rx_ready                input beat accepted when high with i_rx_valid
//   o_pl_valid/data/last/user payload byte stream (user = bad datagram)
//   i_pl_ready                downstream accepts the payload beat
//   o_src_ip, o_src_port      source address/port of the current datagram
//   o_dst_port, o_length      destination port, payload length (UDP len - 8)
//   o_drop                    one-cycle pulse per discarded frame
module udp_rx_parser #(
  parameter logic [31:0] LOCAL_IP = 32'hC0A80180,
  parameter logic [15:0] PORT_LO  = 16'd1234,
  parameter logic [15:0] PORT_HI  = 16'd1236
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_last,
  input  logic        i_rx_user,
  output logic        o_rx_ready,
  output logic        o_pl_valid,
  output logic [7:0]  o_pl_data,
  output logic        o_pl_last,
  output logic        o_pl_user,
  input  logic        i_pl_ready,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic [15:0] o_dst_port,
  output logic [15:0] o_length,
  output logic        o_drop
);

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [IDX_W-1:0] IDX_HDR_END = IDX_W'(41);
  localparam logic [LEN_W-1:0] UDP_HDR_LEN = LEN_W'(8);
  localparam logic [LEN_W-1:0] UDP_MIN_LEN = LEN_W'(9);

  typedef enum logic [2:0] {
    S_HEADER  = 3'd0,
    S_PAYLOAD = 3'd1,
    S_PAD     = 3'd2,
    S_FLUSH   = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [LEN_W-1:0]    udp_len_q,   udp_len_d;
  logic [LEN_W-1:0]    length_q,    length_d;
  logic [31:0]         src_ip_q,    src_ip_d;
  logic [LEN_W-1:0]    src_port_q,  src_port_d;
  logic [LEN_W-1:0]    dst_port_q,  dst_port_d;
  logic [BYTE_W-1:0]   hold_q,      hold_d;
  logic                hold_user_q, hold_user_d;
  logic                drop_q,      drop_d;

  logic                hdr_ok_c;
  logic [LEN_W-1:0]    port_c;
  logic [LEN_W-1:0]    len_c;
  logic                rx_ready_c;
  logic                pl_valid_c;
  logic [BYTE_W-1:0]   pl_data_c;
  logic                pl_last_c;
  logic                pl_user_c;

  // Per-byte header check on the byte currently presented in HEADER.
  // Two-byte fields combine the already captured high byte with the live low byte.
  always_comb begin
    hdr_ok_c = 1'b1;
    port_c   = {dst_port_q[15:8], i_rx_data};
    len_c    = {udp_len_q[15:8], i_rx_data};
    case (idx_q)
      IDX_W'(12): hdr_ok_c = (i_rx_data == 8'h08);
      IDX_W'(13): hdr_ok_c = (i_rx_data == 8'h00);
      IDX_W'(14): hdr_ok_c = (i_rx_data == 8'h45);
      IDX_W'(20): hdr_ok_c = ((i_rx_data & 8'h3F) == 8'h00);
      IDX_W'(21): hdr_ok_c = (i_rx_data == 8'h00);
      IDX_W'(23): hdr_ok_c = (i_rx_data == 8'h11);
      IDX_W'(30): hdr_ok_c = (i_rx_data == LOCAL_IP[31:24]);
      IDX_W'(31): hdr_ok_c = (i_rx_data == LOCAL_IP[23:16]);
      IDX_W'(32): hdr_ok_c = (i_rx_data == LOCAL_IP[15:8]);
      IDX_W'(33): hdr_ok_c = (i_rx_data == LOCAL_IP[7:0]);
      IDX_W'(37): hdr_ok_c = (port_c >= PORT_LO) && (port_c <= PORT_HI);
      IDX_W'(39): hdr_ok_c = (len_c >= UDP_MIN_LEN);
      default:    hdr_ok_c = 1'b1;
    endcase
  end

  // Next-state, capture and stream outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    udp_len_d   = udp_len_q;
    length_d    = length_q;
    src_ip_d    = src_ip_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;
    hold_d      = hold_q;
    hold_user_d = hold_user_q;
    drop_d      = 1'b0;
    rx_ready_c  = 1'b0;
    pl_valid_c  = 1'b0;
    pl_data_c   = '0;
    pl_last_c   = 1'b0;
    pl_user_c   = 1'b0;

    case (state_q)
      S_HEADER: begin
        rx_ready_c = 1'b1;
        if (i_rx_valid) begin
          case (idx_q)
            IDX_W'(26): src_ip_d[31:24]  = i_rx_data;
            IDX_W'(27): src_ip_d[23:16]  = i_rx_data;
            IDX_W'(28): src_ip_d[15:8]   = i_rx_data;
            IDX_W'(29): src_ip_d[7:0]    = i_rx_data;
            IDX_W'(34): src_port_d[15:8] = i_rx_data;
            IDX_W'(35): src_port_d[7:0]  = i_rx_data;
            IDX_W'(36): dst_port_d[15:8] = i_rx_data;
            IDX_W'(37): dst_port_d[7:0]  = i_rx_data;
            IDX_W'(38): udp_len_d[15:8]  = i_rx_data;
            IDX_W'(39): udp_len_d[7:0]   = i_rx_data;
            default: ;
          endcase
          // A frame ending inside the header is discarded right here.
          if (i_rx_last) begin
            drop_d = 1'b1;
            idx_d  = '0;
          end else if (!hdr_ok_c) begin
            state_d = S_DROP;
            idx_d   = '0;
          end else if (idx_q == IDX_HDR_END) begin
            state_d     = S_PAYLOAD;
            idx_d       = '0;
            remaining_d = udp_len_q - UDP_HDR_LEN;
            length_d    = udp_len_q - UDP_HDR_LEN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PAYLOAD: begin
        if (remaining_q > LEN_W'(1)) begin
          // Zero-latency pass-through; an early input last means truncation.
          pl_valid_c = i_rx_valid;
          pl_data_c  = i_rx_data;
          pl_last_c  = i_rx_last;
          pl_user_c  = i_rx_last;
          rx_ready_c = i_pl_ready;
          if (i_rx_valid && i_pl_ready) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (i_rx_last) begin
              state_d = S_HEADER;
            end
          end
        end else begin
          // Final payload byte is held until the frame end reveals its error flag.
          rx_ready_c = 1'b1;
          if (i_rx_valid) begin
            hold_d      = i_rx_data;
            remaining_d = '0;
            if (i_rx_last) begin
              hold_user_d = i_rx_user;
              state_d     = S_FLUSH;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        rx_ready_c = 1'b1;
        if (i_rx_valid && i_rx_last) begin
          hold_user_d = i_rx_user;
          state_d     = S_FLUSH;
        end
      end

      S_FLUSH: begin
        pl_valid_c = 1'b1;
        pl_data_c  = hold_q;
        pl_last_c  = 1'b1;
        pl_user_c  = hold_user_q;
        if (i_pl_ready) begin
          state_d = S_HEADER;
          idx_d   = '0;
        end
      end

      S_DROP: begin
        rx_ready_c = 1'b1;
        if (i_rx_valid && i_rx_last) begin
          drop_d  = 1'b1;
          state_d = S_HEADER;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = S_HEADER;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_HEADER;
      idx_q       <= '0;
      remaining_q <= '0;
      udp_len_q   <= '0;
      length_q    <= '0;
      src_ip_q    <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      hold_q      <= '0;
      hold_user_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      udp_len_q   <= udp_len_d;
      length_q    <= length_d;
      src_ip_q    <= src_ip_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      hold_q      <= hold_d;
      hold_user_q <= hold_user_d;
      drop_q      <= drop_d;
    end
  end

  assign o_rx_ready = rx_ready_c;
  assign o_pl_valid = pl_valid_c;
  assign o_pl_data  = pl_data_c;
  assign o_pl_last  = pl_last_c;
  assign o_pl_user  = pl_user_c;
  assign o_src_ip   = src_ip_q;
  assign o_src_port = src_port_q;
  assign o_dst_port = dst_port_q;
  assign o_length   = length_q;
  assign o_drop     = drop_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed self-checking bench for udp_rx_parser.
module tb_udp_rx_parser;

  logic        i_clock;
  logic        i_reset_n;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_rx_last;
  logic        i_rx_user;
  logic        o_rx_ready;
  logic        o_pl_valid;
  logic [7:0]  o_pl_data;
  logic        o_pl_last;
  logic        o_pl_user;
  logic        i_pl_ready;
  logic [31:0] o_src_ip;
  logic [15:0] o_src_port;
  logic [15:0] o_dst_port;
  logic [15:0] o_length;
  logic        o_drop;

  udp_rx_parser dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .i_rx_last  (i_rx_last),
    .i_rx_user  (i_rx_user),
    .o_rx_ready (o_rx_ready),
    .o_pl_valid (o_pl_valid),
    .o_pl_data  (o_pl_data),
    .o_pl_last  (o_pl_last),
    .o_pl_user  (o_pl_user),
    .i_pl_ready (i_pl_ready),
    .o_src_ip   (o_src_ip),
    .o_src_port (o_src_port),
    .o_dst_port (o_dst_port),
    .o_length   (o_length),
    .o_drop     (o_drop)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  logic [9:0]  beat_q[$];
  int          beat_cyc_q[$];
  int          drops   = 0;
  int          mir_n   = 0;
  int          mir_err = 0;
  logic        mir_en  = 1'b0;
  logic        tog_en  = 1'b0;

  logic [7:0]  frm[$];
  logic [7:0]  pl[$];

  always @(posedge i_clock) cyc <= cyc + 1;

  // Observe outputs at the falling edge, i.e. what the next rising edge transfers.
  always @(negedge i_clock) begin
    if (o_pl_valid && i_pl_ready) begin
      beat_q.push_back({o_pl_user, o_pl_last, o_pl_data});
      beat_cyc_q.push_back(cyc);
    end
    if (o_drop) drops++;
    if (mir_en && o_pl_valid && i_rx_valid) begin
      mir_n++;
      if (o_rx_ready !== i_pl_ready) mir_err++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  // Build a frame into frm from the header fields and the payload in pl.
  task automatic build(input logic [15:0] etype, input logic [7:0] b20,
                       input logic [15:0] dport, input logic [15:0] ulen,
                       input int pad_to);
    logic [15:0] tl;
    tl = ulen + 16'd20;
    frm.delete();
    frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'h02); frm.push_back(8'h11); frm.push_back(8'h22);
    frm.push_back(8'h33); frm.push_back(8'h44); frm.push_back(8'h55);
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(8'h45); frm.push_back(8'h00);
    frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
    frm.push_back(8'h12); frm.push_back(8'h34);
    frm.push_back(b20);   frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h0A);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h80);
    frm.push_back(8'h9C); frm.push_back(8'h40);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    foreach (pl[i]) frm.push_back(pl[i]);
    while (frm.size() < pad_to) frm.push_back(8'h00);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
    int n;
    n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = d;
    i_rx_last  = l;
    i_rx_user  = u;
    @(negedge i_clock);
    while (!o_rx_ready && n < 300) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 300) chk("rx_ready_timeout", 32'(o_rx_ready), 32'd1);
    acc_cyc = cyc;
    @(posedge i_clock);
    #1;
  endtask

  // Send frm[lo..hi-1]; the final byte carries last when with_last is set.
  task automatic send_range(input int lo, input int hi, input logic with_last, input logic u);
    for (int i = lo; i < hi; i++) begin
      if (with_last && i == hi - 1) send_byte(frm[i], 1'b1, u);
      else                          send_byte(frm[i], 1'b0, 1'b0);
    end
    i_rx_valid = 1'b0;
    i_rx_last  = 1'b0;
    i_rx_user  = 1'b0;
  endtask

  // Compare beats collected since base against pl; last beat carries user_exp.
  task automatic check_beats(input string tag, input int base, input logic user_exp);
    int n;
    logic [9:0] b;
    n = beat_q.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(pl.size()));
    for (int i = 0; i < pl.size() && i < n; i++) begin
      b = beat_q[base + i];
      chk({tag, "_data"}, 32'(b[7:0]), 32'(pl[i]));
      chk({tag, "_last"}, 32'(b[8]), 32'(i == pl.size() - 1));
      chk({tag, "_user"}, 32'(b[9]), (i == pl.size() - 1) ? 32'(user_exp) : 32'd0);
    end
  endtask

  task automatic set_good_payload();
    pl.delete();
    pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
  endtask

  int base;
  int dbase;
  int mbase_n;
  int mbase_e;

  initial begin
    i_reset_n  = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_last  = 1'b0;
    i_rx_user  = 1'b0;
    i_pl_ready = 1'b1;
    idle(3);

    // Reset values
    chk("rst_rx_ready", 32'(o_rx_ready), 32'd1);
    chk("rst_pl_valid", 32'(o_pl_valid), 32'd0);
    chk("rst_pl_last",  32'(o_pl_last),  32'd0);
    chk("rst_drop",     32'(o_drop),     32'd0);
    chk("rst_length",   32'(o_length),   32'd0);
    chk("rst_src_ip",   o_src_ip,        32'd0);
    i_reset_n = 1'b1;
    idle(2);

    // Good frame, padded to 60 bytes
    set_good_payload();
    build(16'h0800, 8'h00, 16'd1234, 16'd12, 60);
    base = beat_q.size(); dbase = drops;
    send_range(0, 60, 1'b1, 1'b0);
    idle(4);
    check_beats("good", base, 1'b0);
    if (beat_cyc_q.size() >= base + 4)
      chk("good_last_latency", 32'(beat_cyc_q[base + 3]), 32'(acc_cyc + 1));
    else
      chk("good_last_present", 32'(beat_cyc_q.size()), 32'(base + 4));
    chk("good_length",   32'(o_length),   32'd4);
    chk("good_src_port", 32'(o_src_port), 32'd40000);
    chk("good_dst_port", 32'(o_dst_port), 32'd1234);
    chk("good_src_ip",   o_src_ip,        32'hC0A8010A);
    chk("good_drops",    32'(drops - dbase), 32'd0);

    // Frame error on the final padding byte
    base = beat_q.size();
    send_range(0, 60, 1'b1, 1'b1);
    idle(4);
    check_beats("user", base, 1'b1);

    // Wrong ethertype, then a good frame on the top port
    base = beat_q.size(); dbase = drops;
    build(16'h86DD, 8'h00, 16'd1234, 16'd12, 60);
    send_range(0, 60, 1'b1, 1'b0);
    build(16'h0800, 8'h00, 16'd1236, 16'd12, 60);
    send_range(0, 60, 1'b1, 1'b0);
    idle(4);
    chk("etype_drops", 32'(drops - dbase), 32'd1);
    check_beats("etype_next", base, 1'b0);
    chk("etype_next_dport", 32'(o_dst_port), 32'd1236);

    // Port above range, fragment, zero-length datagram
    base = beat_q.size(); dbase = drops;
    build(16'h0800, 8'h00, 16'd1237, 16'd12, 60);
    send_range(0, 60, 1'b1, 1'b0);
    build(16'h0800, 8'h20, 16'd1234, 16'd12, 60);
    send_range(0, 60, 1'b1, 1'b0);
    pl.delete();
    build(16'h0800, 8'h00, 16'd1234, 16'd8, 60);
    send_range(0, 60, 1'b1, 1'b0);
    idle(4);
    chk("bad_drops", 32'(drops - dbase), 32'd3);
    chk("bad_beats", 32'(beat_q.size() - base), 32'd0);

    // Minimum length datagram: single payload byte
    pl.delete(); pl.push_back(8'hA5);
    base = beat_q.size();
    build(16'h0800, 8'h00, 16'd1234, 16'd9, 60);
    send_range(0, 60, 1'b1, 1'b0);
    idle(4);
    check_beats("one", base, 1'b0);
    chk("one_length", 32'(o_length), 32'd1);

    // Truncated: UDP length 108 but only 10 payload bytes
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(i * 7 + 3));
    base = beat_q.size(); dbase = drops;
    build(16'h0800, 8'h00, 16'd1235, 16'd108, 0);
    send_range(0, 52, 1'b1, 1'b0);
    idle(3);
    check_beats("trunc", base, 1'b1);
    chk("trunc_ready", 32'(o_rx_ready), 32'd1);
    chk("trunc_valid", 32'(o_pl_valid), 32'd0);
    chk("trunc_drops", 32'(drops - dbase), 32'd0);
    chk("trunc_length", 32'(o_length), 32'd100);

    // Backpressure toggling during a 64-byte payload
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i * 3 + 1));
    build(16'h0800, 8'h00, 16'd1234, 16'd72, 0);
    base = beat_q.size(); mbase_n = mir_n; mbase_e = mir_err;
    mir_en = 1'b1;
    tog_en = 1'b1;
    fork
      begin
        send_range(0, 106, 1'b1, 1'b0);
        tog_en = 1'b0;
      end
      begin
        while (tog_en) begin
          @(posedge i_clock);
          #1;
          if (tog_en) i_pl_ready = ~i_pl_ready;
        end
      end
    join
    i_pl_ready = 1'b1;
    idle(4);
    mir_en = 1'b0;
    check_beats("bp", base, 1'b0);
    chk("bp_mirror_err", 32'(mir_err - mbase_e), 32'd0);
    chk("bp_mirror_seen", 32'((mir_n - mbase_n) >= 63), 32'd1);
    chk("bp_length", 32'(o_length), 32'd64);

    // Reset in the middle of the payload
    send_range(0, 47, 1'b0, 1'b0);
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(o_pl_valid), 32'd0);
    chk("mid_rst_ready",  32'(o_rx_ready), 32'd1);
    chk("mid_rst_length", 32'(o_length),   32'd0);
    chk("mid_rst_sport",  32'(o_src_port), 32'd0);
    chk("mid_rst_drop",   32'(o_drop),     32'd0);
    idle(2);
    i_reset_n = 1'b1;
    idle(1);
    base = beat_q.size(); dbase = drops;
    send_range(47, 106, 1'b1, 1'b0);
    idle(3);
    chk("tail_drops", 32'(drops - dbase), 32'd1);
    chk("tail_beats", 32'(beat_q.size() - base), 32'd0);
    set_good_payload();
    build(16'h0800, 8'h00, 16'd1234, 16'd12, 60);
    base = beat_q.size();
    send_range(0, 60, 1'b1, 1'b0);
    idle(4);
    check_beats("after_rst", base, 1'b0);
    chk("after_rst_length", 32'(o_length), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
